// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle main controller for the MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath control inputs.
// Optional feature macro: MC_MEM_STALL_EN (adds mem_ready; MEM holds until ready).
module mc_control_unit #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPcode,
  input  logic [5:0] funct,
  input  logic       ALUZero,
`ifdef MC_MEM_STALL_EN
  input  logic       mem_ready,
`endif
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       SgnZero,
  output logic [2:0] ALUOP,
  output logic [2:0] state,
  output logic       illegal
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned AOP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [AOP_W-1:0] AOP_AND = 3'b000;
  localparam logic [AOP_W-1:0] AOP_OR  = 3'b001;
  localparam logic [AOP_W-1:0] AOP_ADD = 3'b010;
  localparam logic [AOP_W-1:0] AOP_SUB = 3'b110;
  localparam logic [AOP_W-1:0] AOP_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_RTYPE, K_LW, K_SW, K_BEQ, K_IMM
  } kind_t;

  state_t            state_q;
  kind_t             kind_q;
  logic [AOP_W-1:0]  alu_op_q;
  logic              alu_src_q;
  logic              reg_dst_q;
  logic              mem_to_reg_q;
  logic              sgn_zero_q;
  logic              ir_write_q;
  logic              pc_write_q;
  logic              reg_write_q;
  logic              mem_write_q;
  logic              illegal_q;

  kind_t             dec_kind;
  logic              dec_legal;
  logic [AOP_W-1:0]  dec_alu_op;
  logic              dec_alu_src;
  logic              dec_reg_dst;
  logic              dec_mem_to_reg;
  logic              dec_sgn_zero;
  logic              mem_go;

`ifdef MC_MEM_STALL_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // Instruction decoder on the live opcode/funct, consumed only in DECODE
  always_comb begin
    dec_kind       = K_NOP;
    dec_legal      = 1'b0;
    dec_alu_op     = AOP_AND;
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_sgn_zero   = 1'b0;
    case (OPcode)
      OP_RTYPE: begin
        dec_kind    = K_RTYPE;
        dec_legal   = 1'b1;
        dec_reg_dst = 1'b1;
        case (funct)
          FN_ADD:  dec_alu_op = AOP_ADD;
          FN_SUB:  dec_alu_op = AOP_SUB;
          FN_AND:  dec_alu_op = AOP_AND;
          FN_OR:   dec_alu_op = AOP_OR;
          FN_SLT:  dec_alu_op = AOP_SLT;
          default: begin
            dec_kind    = K_NOP;
            dec_legal   = 1'b0;
            dec_reg_dst = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        dec_kind       = K_LW;
        dec_legal      = 1'b1;
        dec_alu_op     = AOP_ADD;
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_kind    = K_SW;
        dec_legal   = 1'b1;
        dec_alu_op  = AOP_ADD;
        dec_alu_src = 1'b1;
      end
      OP_BEQ: begin
        dec_kind   = K_BEQ;
        dec_legal  = 1'b1;
        dec_alu_op = AOP_SUB;
      end
      OP_ADDI: begin
        dec_kind    = K_IMM;
        dec_legal   = 1'b1;
        dec_alu_op  = AOP_ADD;
        dec_alu_src = 1'b1;
      end
      OP_ANDI: begin
        dec_kind     = K_IMM;
        dec_legal    = 1'b1;
        dec_alu_op   = AOP_AND;
        dec_alu_src  = 1'b1;
        dec_sgn_zero = 1'b1;
      end
      OP_ORI: begin
        dec_kind     = K_IMM;
        dec_legal    = 1'b1;
        dec_alu_op   = AOP_OR;
        dec_alu_src  = 1'b1;
        dec_sgn_zero = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer: state plus registered controls for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      kind_q       <= K_NOP;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      sgn_zero_q   <= 1'b0;
      ir_write_q   <= 1'b1;
      pc_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          state_q    <= S_DECODE;
          ir_write_q <= 1'b0;
        end
        S_DECODE: begin
          if (dec_legal) begin
            // decoded form of the instruction is frozen here until retire
            state_q      <= S_EXEC;
            kind_q       <= dec_kind;
            alu_op_q     <= dec_alu_op;
            alu_src_q    <= dec_alu_src;
            reg_dst_q    <= dec_reg_dst;
            mem_to_reg_q <= dec_mem_to_reg;
            sgn_zero_q   <= dec_sgn_zero;
            pc_write_q   <= (dec_kind == K_BEQ);
          end else if (HALT_ON_ILLEGAL) begin
            state_q   <= S_ERR;
            illegal_q <= 1'b1;
          end else begin
            state_q    <= S_EXEC;
            kind_q     <= K_NOP;
            pc_write_q <= 1'b1;
            illegal_q  <= 1'b1;
          end
        end
        S_EXEC: begin
          case (kind_q)
            K_LW: state_q <= S_MEM;
            K_SW: begin
              state_q     <= S_MEM;
              mem_write_q <= 1'b1;
              pc_write_q  <= 1'b1;
            end
            K_RTYPE, K_IMM: begin
              state_q     <= S_WB;
              reg_write_q <= 1'b1;
              pc_write_q  <= 1'b1;
            end
            default: begin
              state_q      <= S_FETCH;
              kind_q       <= K_NOP;
              alu_op_q     <= '0;
              alu_src_q    <= 1'b0;
              reg_dst_q    <= 1'b0;
              mem_to_reg_q <= 1'b0;
              sgn_zero_q   <= 1'b0;
              ir_write_q   <= 1'b1;
              pc_write_q   <= 1'b0;
              illegal_q    <= 1'b0;
            end
          endcase
        end
        S_MEM: begin
          if (mem_go) begin
            if (kind_q == K_LW) begin
              state_q     <= S_WB;
              reg_write_q <= 1'b1;
              pc_write_q  <= 1'b1;
            end else begin
              state_q      <= S_FETCH;
              kind_q       <= K_NOP;
              alu_op_q     <= '0;
              alu_src_q    <= 1'b0;
              reg_dst_q    <= 1'b0;
              mem_to_reg_q <= 1'b0;
              sgn_zero_q   <= 1'b0;
              ir_write_q   <= 1'b1;
              pc_write_q   <= 1'b0;
              mem_write_q  <= 1'b0;
            end
          end
        end
        S_ERR: state_q <= S_ERR;
        default: begin
          // WB and the unused encodings all return to FETCH
          state_q      <= S_FETCH;
          kind_q       <= K_NOP;
          alu_op_q     <= '0;
          alu_src_q    <= 1'b0;
          reg_dst_q    <= 1'b0;
          mem_to_reg_q <= 1'b0;
          sgn_zero_q   <= 1'b0;
          ir_write_q   <= 1'b1;
          pc_write_q   <= 1'b0;
          reg_write_q  <= 1'b0;
          mem_write_q  <= 1'b0;
          illegal_q    <= 1'b0;
        end
      endcase
    end
  end

  // Write strobes are killed immediately by reset; sw PC update waits for memory
  assign IRWrite  = ir_write_q & ~reset;
  assign RegWrite = reg_write_q & ~reset;
  assign MemWrite = mem_write_q & ~reset;
  assign PCWrite  = pc_write_q & ~reset & ((state_q != S_MEM) | mem_go);
  assign PCSrc    = (state_q == S_EXEC) & (kind_q == K_BEQ) & ALUZero;

  assign MemtoReg = mem_to_reg_q;
  assign RegDst   = reg_dst_q;
  assign ALUSrc   = alu_src_q;
  assign SgnZero  = sgn_zero_q;
  assign ALUOP    = alu_op_q;
  assign state    = state_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-cycle output vectors checked through a scoreboard.
// Two instances share inputs: HALT_ON_ILLEGAL=1 (dut_a) and 0 (dut_b).
module tb_mc_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] OPcode;
  logic [5:0] funct;
  logic       ALUZero;
  logic       mem_ready;

  logic       ir_a, pw_a, ps_a, rw_a, mw_a, m2r_a, rd_a, as_a, sz_a, ill_a;
  logic [2:0] aop_a, st_a;
  logic       ir_b, pw_b, ps_b, rw_b, mw_b, m2r_b, rd_b, as_b, sz_b, ill_b;
  logic [2:0] aop_b, st_b;

  mc_control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .OPcode(OPcode), .funct(funct), .ALUZero(ALUZero),
`ifdef MC_MEM_STALL_EN
    .mem_ready(mem_ready),
`endif
    .IRWrite(ir_a), .PCWrite(pw_a), .PCSrc(ps_a), .RegWrite(rw_a), .MemWrite(mw_a),
    .MemtoReg(m2r_a), .RegDst(rd_a), .ALUSrc(as_a), .SgnZero(sz_a), .ALUOP(aop_a),
    .state(st_a), .illegal(ill_a)
  );

  mc_control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .OPcode(OPcode), .funct(funct), .ALUZero(ALUZero),
`ifdef MC_MEM_STALL_EN
    .mem_ready(mem_ready),
`endif
    .IRWrite(ir_b), .PCWrite(pw_b), .PCSrc(ps_b), .RegWrite(rw_b), .MemWrite(mw_b),
    .MemtoReg(m2r_b), .RegDst(rd_b), .ALUSrc(as_b), .SgnZero(sz_b), .ALUOP(aop_b),
    .state(st_b), .illegal(ill_b)
  );

  logic [15:0] act_a, act_b;
  assign act_a = {st_a, ir_a, pw_a, ps_a, rw_a, mw_a, m2r_a, rd_a, as_a, sz_a, aop_a, ill_a};
  assign act_b = {st_b, ir_b, pw_b, ps_b, rw_b, mw_b, m2r_b, rd_b, as_b, sz_b, aop_b, ill_b};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    int          ncyc;
    logic [14:0] seq;
    logic [4:0]  rw;
    logic [4:0]  mw;
    logic [4:0]  pw;
    logic [2:0]  aluop;
    logic        as;
    logic        rd;
    logic        m2r;
    logic        sz;
    logic        ps;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          id;
  } sb_t;

  sb_t sb[$];
  sb_t chk;
  int  checks = 0;
  int  errors = 0;
  vec_t vecs[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [2:0] st, input logic ir, input logic pw,
                                     input logic ps, input logic rw, input logic mw,
                                     input logic m2r, input logic rd, input logic as,
                                     input logic sz, input logic [2:0] aop, input logic ill);
    return {st, ir, pw, ps, rw, mw, m2r, rd, as, sz, aop, ill};
  endfunction

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int n, input logic [14:0] seq, input logic [4:0] rw,
                               input logic [4:0] mw, input logic [4:0] pw, input logic [2:0] aop,
                               input logic as, input logic rd, input logic m2r,
                               input logic sz, input logic ps);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = z; v.ncyc = n; v.seq = seq;
    v.rw = rw; v.mw = mw; v.pw = pw; v.aluop = aop;
    v.as = as; v.rd = rd; v.m2r = m2r; v.sz = sz; v.ps = ps;
    return v;
  endfunction

  task automatic push(input logic [15:0] a, input logic [15:0] b, input int id);
    sb_t it;
    it.a = a; it.b = b; it.id = id;
    sb.push_back(it);
  endtask

  // Scoreboard consumer: compare both instances mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      chk = sb.pop_front();
      checks++;
      if (act_a !== chk.a) begin
        errors++;
        $display("FAIL sb id=%0d dut_a actual=%h required=%h", chk.id, act_a, chk.a);
      end
      checks++;
      if (act_b !== chk.b) begin
        errors++;
        $display("FAIL sb id=%0d dut_b actual=%h required=%h", chk.id, act_b, chk.b);
      end
    end
  end

  task automatic do_reset(input int id);
    logic [15:0] z;
    z = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push(z, z, id);
  endtask

  task automatic run_vec(input vec_t v, input bit corrupt, input int id);
    logic [15:0] e;
    logic [2:0]  st;
    logic        late;
    for (int c = 0; c < v.ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        reset = 1'b0; OPcode = v.op; funct = v.fn; ALUZero = v.zero;
      end
      st   = v.seq[c*3 +: 3];
      late = (c >= 2);
      e = mk(st, c == 0, v.pw[c], v.ps & (c == 2), v.rw[c], v.mw[c], late & v.m2r,
             late & v.rd, late & v.as, late & v.sz, late ? v.aluop : 3'b000, 1'b0);
      push(e, e, id * 8 + c);
      if (corrupt && c == 2) begin
        OPcode = 6'h2B; funct = 6'h20;
      end
    end
  endtask

  initial begin
    logic [14:0] seq4, seq5, seqm, seq3;
    logic [15:0] ea, eb, z;
    vec_t v;
    int   m;

    reset = 1'b1; OPcode = 6'h00; funct = 6'h00; ALUZero = 1'b0; mem_ready = 1'b1;

    seq4 = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
    seq5 = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    seqm = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
    seq3 = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
    z    = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

    //             op     fn     z  n  seq   rw        mw        pw        aop    as rd m2r sz ps
    vecs[0]  = mkv(6'h00, 6'h20, 1, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b010, 0, 1, 0, 0, 0);
    vecs[1]  = mkv(6'h00, 6'h22, 0, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b110, 0, 1, 0, 0, 0);
    vecs[2]  = mkv(6'h00, 6'h24, 0, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b000, 0, 1, 0, 0, 0);
    vecs[3]  = mkv(6'h00, 6'h25, 1, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b001, 0, 1, 0, 0, 0);
    vecs[4]  = mkv(6'h00, 6'h2A, 0, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b111, 0, 1, 0, 0, 0);
    vecs[5]  = mkv(6'h23, 6'h3F, 0, 5, seq5, 5'b10000, 5'b00000, 5'b10000, 3'b010, 1, 0, 1, 0, 0);
    vecs[6]  = mkv(6'h2B, 6'h11, 1, 4, seqm, 5'b00000, 5'b01000, 5'b01000, 3'b010, 1, 0, 0, 0, 0);
    vecs[7]  = mkv(6'h04, 6'h00, 1, 3, seq3, 5'b00000, 5'b00000, 5'b00100, 3'b110, 0, 0, 0, 0, 1);
    vecs[8]  = mkv(6'h04, 6'h00, 0, 3, seq3, 5'b00000, 5'b00000, 5'b00100, 3'b110, 0, 0, 0, 0, 0);
    vecs[9]  = mkv(6'h08, 6'h20, 0, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b010, 1, 0, 0, 0, 0);
    vecs[10] = mkv(6'h0C, 6'h00, 1, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b000, 1, 0, 0, 1, 0);
    vecs[11] = mkv(6'h0D, 6'h25, 0, 4, seq4, 5'b01000, 5'b00000, 5'b01000, 3'b001, 1, 0, 0, 1, 0);

    do_reset(900);
    for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0, i);

    // andi with OPcode switched to sw during EXEC: controls must not follow
    run_vec(vecs[10], 1'b1, 20);

    // reset arriving in MEM of sw kills MemWrite/PCWrite that same cycle
    v = vecs[6]; v.ncyc = 3;
    run_vec(v, 1'b0, 30);
    @(posedge clk); #1;
    reset = 1'b1;
    ea = mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b010, 0);
    push(ea, ea, 31 * 8);
    @(posedge clk); #1;
    push(z, z, 31 * 8 + 1);
    run_vec(vecs[0], 1'b0, 32);

    // illegal opcode: dut_a parks in ERR, dut_b retires repeated 3-cycle NOPs
    @(posedge clk); #1;
    reset = 1'b0; OPcode = 6'h3F; funct = 6'h00; ALUZero = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c == 0)      ea = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      else if (c == 1) ea = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      else             ea = mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
      m = c % 3;
      if (m == 0)      eb = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      else if (m == 1) eb = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      else             eb = mk(3'd2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
      push(ea, eb, 40 * 8 + c);
    end
    do_reset(41);
    run_vec(vecs[5], 1'b0, 42);

`ifdef MC_MEM_STALL_EN
    // sw with memory not ready for three MEM cycles
    v = vecs[6]; v.ncyc = 3;
    run_vec(v, 1'b0, 50);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == 3);
      ea = mk(3'd3, 0, k == 3, 0, 0, 1, 0, 0, 1, 0, 3'b010, 0);
      push(ea, ea, 51 * 8 + k);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    ea = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    push(ea, ea, 52 * 8);
    v = vecs[0]; v.ncyc = 4;
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      OPcode = 6'h00; funct = 6'h20;
      if (c == 1) ea = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      else if (c == 2) ea = mk(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b010, 0);
      else ea = mk(3'd4, 0, 1, 0, 1, 0, 0, 1, 0, 0, 3'b010, 0);
      push(ea, ea, 52 * 8 + c);
    end
`endif

    run_vec(vecs[7], 1'b0, 60);
    run_vec(vecs[0], 1'b0, 61);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle main controller that drives the control inputs of the MIPS-subset datapath: MemtoReg, MemWrite, PCSrc, ALUSrc, RegDst, RegWrite, SgnZero, ALUOP.
- It also provides the PC and instruction-register enables that the datapath needs when it moves to multi-cycle operation.
- Consumes OPcode, funct and ALUZero from the datapath and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an illegal instruction parks the FSM in ERR; 0: an illegal instruction retires as a NOP.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
OPcode  input  6  instruction[31:26] from datapath
funct  input  6  instruction[5:0] from datapath
ALUZero  input  1  ALU zero flag from datapath
IRWrite  output  1  latch instruction (FETCH only)
PCWrite  output  1  PC update strobe, one cycle per retired instruction
PCSrc  output  1  1 = branch target, 0 = PC+4
RegWrite  output  1  register file write strobe
MemWrite  output  1  data memory write strobe
MemtoReg  output  1  1 = memory data to register file
RegDst  output  1  1 = rd, 0 = rt
ALUSrc  output  1  1 = immediate
SgnZero  output  1  1 = zero-extend immediate, 0 = sign-extend
ALUOP  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7
illegal  output  1  illegal-instruction flag

Behaviour:
- Reset (synchronous): state<=FETCH and illegal<=0; all outputs are 0 after the edge.
- While reset=1, RegWrite, MemWrite, PCWrite and IRWrite are forced 0 combinationally, including when reset arrives mid-instruction. The next instruction restarts at FETCH.
- Decode: {OPcode, funct} are latched into internal registers on leaving DECODE. Changes on OPcode/funct after that point are ignored until the next FETCH.
- Supported encodings:
  - R-type, opcode 0x00: funct 0x20 add (010), 0x22 sub (110), 0x24 and (000), 0x25 or (001), 0x2A slt (111).
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, andi 0x0C, ori 0x0D.
- State sequences and cycle counts:
  - R-type: FETCH, DECODE, EXEC, WB (4 cycles).
  - lw: FETCH, DECODE, EXEC, MEM, WB (5 cycles).
  - sw: FETCH, DECODE, EXEC, MEM (4 cycles).
  - beq: FETCH, DECODE, EXEC (3 cycles).
  - addi/andi/ori: FETCH, DECODE, EXEC, WB (4 cycles).
- FETCH: IRWrite=1; all other outputs 0. DECODE: all outputs 0.
- From EXEC to the last state of the instruction, the static controls are held constant:
  - ALUOP: funct-mapped for R-type; 010 for lw/sw/addi; 110 for beq; 000 for andi; 001 for ori.
  - ALUSrc=1 for lw/sw/addi/andi/ori.
  - RegDst=1 for R-type only.
  - MemtoReg=1 for lw only.
  - SgnZero=1 for andi/ori only.
- Strobe timing:
  - RegWrite=1 only in WB.
  - MemWrite=1 only in MEM of sw.
  - PCWrite=1 only in the final state of each instruction; then next state = FETCH.
  - PCSrc = beq & ALUZero, sampled in EXEC; 0 in all other cases.
- Illegal instruction = unknown opcode, or unknown funct when opcode is 0x00.
  - HALT_ON_ILLEGAL=1: DECODE -> ERR. In ERR, illegal=1, all strobes are 0, and the FSM stays until reset.
  - HALT_ON_ILLEGAL=0: the instruction runs FETCH, DECODE, EXEC with no write strobes and PCWrite=1, PCSrc=0 in EXEC. illegal pulses high for that EXEC cycle only.
- Unused state encodings 5 and 6 go to FETCH on the next clock.

Optional Feature:
MC_MEM_STALL_EN
- Defined:
  - Adds input mem_ready (1 bit).
  - The MEM state holds while mem_ready=0. MemWrite (sw) stays asserted for every MEM cycle.
  - PCWrite (sw) is asserted only in the MEM cycle where mem_ready=1.
  - lw advances to WB only on mem_ready=1.
  - reset overrides a pending stall.
- Undefined: the port is absent and MEM always lasts exactly 1 cycle.

Test Plan:
- Reset, then add (OPcode 0x00, funct 0x20):
  - state sequence 0,1,2,4,0.
  - In WB: RegWrite=1, RegDst=1, ALUOP=010, PCWrite=1.
  - No MemWrite at any point.
- lw 0x23 -> 5 cycles.
  - MemtoReg=1 and ALUSrc=1 from EXEC through WB.
  - RegWrite only in cycle 5; PCWrite only in cycle 5.
- beq 0x04:
  - ALUZero=1 in EXEC -> PCSrc=1, PCWrite=1, ALUOP=110, 3 cycles total.
  - Repeat with ALUZero=0 -> PCSrc=0.
- andi 0x0C -> SgnZero=1, ALUOP=000, RegDst=0. Change OPcode to 0x2B during EXEC -> outputs unchanged and no MemWrite.
- Opcode 0x3F:
  - HALT_ON_ILLEGAL=1: state=7 and illegal=1 held for 10 cycles; reset then returns the FSM to FETCH.
  - HALT_ON_ILLEGAL=0: 3-cycle NOP, illegal pulses 1 cycle.
- Reset asserted in MEM of sw: MemWrite=0 in that cycle; state=0 after the edge.
  - With MC_MEM_STALL_EN defined, sw with mem_ready low for 3 cycles: MemWrite is high for 4 cycles and PCWrite pulses once.
